// File: rtl/timer_peripheral_if.sv
// timer_peripheral_if: CPU MEM-stage data bus between the CPU and a memory-mapped responder.
interface timer_peripheral_if;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        Hit;
    modport master (output Address, Write_data, MemRead, MemWrite, input Read_data, Hit);
    modport slave  (input Address, Write_data, MemRead, MemWrite, output Read_data, Hit);
endinterface

// File: rtl/timer_peripheral.sv
// timer_peripheral: bus-mapped interval timer with IRQ, LED and 7-segment registers.
// Define TIMER_SYSTICK_EN to add the free-running SYSTICK counter at word 5.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic               clk,
    input  logic               reset,
    timer_peripheral_if.slave  bus,
    output logic               IRQ,
    output logic [7:0]         leds,
    output logic [11:0]        digits
);
    localparam logic [15:0] PLAST = 16'(PRESCALE - 1);
    logic [31:0] th, tl, systick, rd;
    logic [15:0] pcnt;
    logic [2:0]  tcon, sel;
    logic        wr, tick, ovf, set_ovf, unused;
    assign unused  = ^bus.Address[1:0];
    assign sel     = bus.Address[4:2];
    assign bus.Hit = bus.Address[31:5] == BASE_ADDR[31:5];
    assign wr      = bus.MemWrite & bus.Hit;
    assign tick    = tcon[0] & (pcnt == PLAST);
    // A TL write in a tick cycle swallows the tick, so no overflow either
    assign ovf     = tick & (tl == 32'hFFFF_FFFF) & ~(wr & sel == 3'd1);
    assign set_ovf = ovf & tcon[1];
    assign IRQ     = tcon[1] & tcon[2];
    always_comb begin
        rd = '0;
        case (sel)
            3'd0: rd = th;
            3'd1: rd = tl;
            3'd2: rd = {29'b0, tcon};
            3'd3: rd = {24'b0, leds};
            3'd4: rd = {20'b0, digits};
            3'd5: rd = systick;
            default: rd = '0;
        endcase
    end
    assign bus.Read_data = (bus.MemRead & bus.Hit) ? rd : 32'h0;
    always_ff @(posedge clk) begin
        if (reset) begin
            th     <= '0;
            tl     <= '0;
            tcon   <= '0;
            leds   <= '0;
            digits <= '0;
            pcnt   <= '0;
        end else begin
            pcnt <= (~tcon[0] | tick | (wr & sel == 3'd2 & ~bus.Write_data[0])) ? 16'd0 : pcnt + 16'd1;
            if (wr & sel == 3'd0) th <= bus.Write_data;
            if (wr & sel == 3'd1) tl <= bus.Write_data;
            else if (tick) tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
            if (wr & sel == 3'd2) tcon <= {bus.Write_data[2] | set_ovf, bus.Write_data[1:0]};
            else if (set_ovf) tcon[2] <= 1'b1;
            if (wr & sel == 3'd3) leds <= bus.Write_data[7:0];
            if (wr & sel == 3'd4) digits <= bus.Write_data[11:0];
        end
    end
`ifdef TIMER_SYSTICK_EN
    always_ff @(posedge clk) systick <= reset ? 32'h0 : systick + 32'd1;
`else
    assign systick = 32'h0;
`endif
endmodule

// File: tb/tb_timer_peripheral.sv
// tb_timer_peripheral: directed checks of timer_peripheral at PRESCALE=1 and PRESCALE=4.
module tb_timer_peripheral;
    localparam logic [31:0] B = 32'h4000_0000;
    logic clk = 0, reset = 1;
    int checks = 0, errors = 0;
    logic [31:0] r, r2;
    logic irq1, irq4;
    logic [7:0] leds1, leds4;
    logic [11:0] dig1, dig4;
    timer_peripheral_if b1();
    timer_peripheral_if b4();
    timer_peripheral #(.BASE_ADDR(B), .PRESCALE(1)) d1 (.clk(clk), .reset(reset), .bus(b1), .IRQ(irq1), .leds(leds1), .digits(dig1));
    timer_peripheral #(.BASE_ADDR(B), .PRESCALE(4)) d4 (.clk(clk), .reset(reset), .bus(b4), .IRQ(irq4), .leds(leds4), .digits(dig4));
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit p, input int w, input logic [31:0] d);
        if (p) begin b4.Address = B + 32'(w * 4); b4.Write_data = d; b4.MemWrite = 1; end
        else   begin b1.Address = B + 32'(w * 4); b1.Write_data = d; b1.MemWrite = 1; end
        step(1);
        b1.MemWrite = 0;
        b4.MemWrite = 0;
    endtask

    task automatic rd(input bit p, input int w, output logic [31:0] d);
        if (p) begin b4.Address = B + 32'(w * 4); b4.MemRead = 1; end
        else   begin b1.Address = B + 32'(w * 4); b1.MemRead = 1; end
        #1;
        d = p ? b4.Read_data : b1.Read_data;
        b1.MemRead = 0;
        b4.MemRead = 0;
    endtask

    initial begin
        {b1.Address, b1.Write_data, b1.MemRead, b1.MemWrite} = '0;
        {b4.Address, b4.Write_data, b4.MemRead, b4.MemWrite} = '0;
        step(2);
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            rd(0, i, r);
            chk($sformatf("reset_word%0d", i), r, 32'h0);
        end
        chk("reset_irq", {30'b0, irq1, irq4}, 32'h0);
        chk("reset_leds", {24'b0, leds1}, 32'h0);
        chk("reset_digits", {20'b0, dig1}, 32'h0);
        b1.Address = 32'h4000_0020;
        b1.MemRead = 1;
        #1;
        chk("miss_hit", {31'b0, b1.Hit}, 32'h0);
        chk("miss_data", b1.Read_data, 32'h0);
        b1.Address = 32'h4000_0004;
        #1;
        chk("hit_word1", {31'b0, b1.Hit}, 32'h1);
        b1.MemRead = 0;
        step(1);

        // PRESCALE=1 reload and IRQ
        wr(0, 0, 32'hFFFF_FFFD);
        wr(0, 1, 32'hFFFF_FFFD);
        wr(0, 2, 32'h3);
        rd(0, 1, r); chk("tl_start", r, 32'hFFFF_FFFD);
        step(1); rd(0, 1, r); chk("tl_fffe", r, 32'hFFFF_FFFE);
        chk("irq_pre", {31'b0, irq1}, 32'h0);
        step(1); rd(0, 1, r); chk("tl_ffff", r, 32'hFFFF_FFFF);
        step(1); rd(0, 1, r); chk("tl_reload", r, 32'hFFFF_FFFD);
        chk("irq_set", {31'b0, irq1}, 32'h1);
        rd(0, 2, r); chk("tcon_ovf", r, 32'h7);
        wr(0, 2, 32'h3);
        chk("irq_clear", {31'b0, irq1}, 32'h0);
        rd(0, 1, r); chk("tl_running", r, 32'hFFFF_FFFE);
        step(1); rd(0, 1, r); chk("tl_ffff2", r, 32'hFFFF_FFFF);
        wr(0, 2, 32'h3);
        rd(0, 2, r); chk("tcon_set_wins", r, 32'h7);
        chk("irq_set_wins", {31'b0, irq1}, 32'h1);
        rd(0, 1, r); chk("tl_reload2", r, 32'hFFFF_FFFD);
        wr(0, 1, 32'hFFFF_FFFE);
        rd(0, 1, r); chk("tl_write_wins", r, 32'hFFFF_FFFE);
        step(1);
        wr(0, 0, 32'h1234);
        rd(0, 1, r); chk("tl_old_th", r, 32'hFFFF_FFFD);
        rd(0, 0, r); chk("th_new", r, 32'h1234);
        wr(0, 2, 32'h0);
        chk("irq_off", {31'b0, irq1}, 32'h0);
        rd(0, 1, r);
        step(3); rd(0, 1, r2); chk("tl_frozen", r2, r);

        // LED / DIGI with concurrent read
        b1.Address = B + 32'hC; b1.Write_data = 32'h1A5; b1.MemRead = 1; b1.MemWrite = 1;
        #1; chk("led_old", b1.Read_data, 32'h0);
        step(1);
        b1.MemWrite = 0; b1.MemRead = 0;
        chk("leds_out", {24'b0, leds1}, 32'hA5);
        rd(0, 3, r); chk("led_read", r, 32'hA5);
        b1.Address = B + 32'hC; b1.Write_data = 32'h5A; b1.MemRead = 1; b1.MemWrite = 1;
        #1; chk("led_old2", b1.Read_data, 32'hA5);
        step(1);
        b1.Address = B + 32'h10; b1.Write_data = 32'hF3C7;
        #1; chk("digi_old", b1.Read_data, 32'h0);
        step(1);
        b1.MemWrite = 0; b1.MemRead = 0;
        chk("leds_out2", {24'b0, leds1}, 32'h5A);
        chk("digits_out", {20'b0, dig1}, 32'h3C7);
        rd(0, 4, r); chk("digi_read", r, 32'h3C7);
        wr(0, 6, 32'hFFFF_FFFF);
        rd(0, 6, r); chk("word6_ignored", r, 32'h0);

        // SYSTICK
        wr(0, 5, 32'h55);
        rd(0, 5, r);
`ifdef TIMER_SYSTICK_EN
        step(10);
        rd(0, 5, r2);
        chk("systick_delta", r2 - r, 32'd10);
        chk("systick_nowrite", {31'b0, (r - 32'h55) < 32'd5}, 32'h0);
`else
        chk("systick_absent", r, 32'h0);
`endif

        // PRESCALE=4 enable, freeze, restart
        wr(1, 1, 32'h0);
        wr(1, 2, 32'h1);
        step(3); rd(1, 1, r); chk("p4_tl_3clk", r, 32'h0);
        step(1); rd(1, 1, r); chk("p4_tl_4clk", r, 32'h1);
        step(3); rd(1, 1, r); chk("p4_tl_7clk", r, 32'h1);
        step(1); rd(1, 1, r); chk("p4_tl_8clk", r, 32'h2);
        step(2);
        wr(1, 2, 32'h0);
        step(10); rd(1, 1, r); chk("p4_frozen", r, 32'h2);
        wr(1, 2, 32'h1);
        step(3); rd(1, 1, r); chk("p4_restart_3", r, 32'h2);
        step(1); rd(1, 1, r); chk("p4_restart_4", r, 32'h3);
        chk("p4_irq", {31'b0, irq4}, 32'h0);

        // reset overrides a running timer
        reset = 1;
        step(1);
        reset = 0;
        rd(1, 1, r); chk("p4_reset_tl", r, 32'h0);
        rd(1, 2, r); chk("p4_reset_tcon", r, 32'h0);
        rd(0, 3, r); chk("reset_led_again", r, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
